// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    // Transaction phases: waiting for operands, shifting bits, presenting result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Borrow when the minuend bit is smaller than subtrahend plus incoming borrow.
    always_comb begin
        diff = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// A single full_subtractor cell is reused across all WIDTH bit positions.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] d_shift;

    full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB so the LSB-first stream ends up in order.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign d_shift = cell_diff;
        end else begin : g_shift_wn
            assign d_shift = {cell_diff, d_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // State, shift registers, borrow and counter; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: load in IDLE, shift one bit per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                d_sr_d   = d_shift;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode registered state only; result comes straight from registers.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_sr_q;
    assign bout      = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic         in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, bout;
    logic [W-1:0] d;

    // WIDTH=1 instance signals
    logic         in_valid1 = 1'b0, out_ready1 = 1'b0, bin1 = 1'b0;
    logic [0:0]   a1 = '0, b1 = '0;
    logic         in_ready1, out_valid1, bout1;
    logic [0:0]   d1;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .d(d1), .bout(bout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction; bit w of the result is the borrow.
    function automatic int model_sub(input int w, input int x, input int y, input int z);
        int diff;
        diff = x - y - z;
        return ((diff < 0) ? (1 << w) : 0) | (diff & ((1 << w) - 1));
    endfunction

    // Transaction-level model: accepted at cycle acc, result valid from acc+W until taken.
    int cyc8 = 0, acc8 = 0, exp8 = 0;
    bit pend8 = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend8 <= 1'b0;
            cyc8  <= 0;
            acc8  <= 0;
        end else begin
            if (pend8 && cyc8 >= acc8 + W && out_ready) begin
                pend8 <= 1'b0;
            end else if (!pend8 && in_valid) begin
                pend8 <= 1'b1;
                acc8  <= cyc8 + 1;
                exp8  <= model_sub(W, int'(a), int'(b), int'(bin));
            end
            cyc8 <= cyc8 + 1;
        end
    end

    int cyc1 = 0, acc1 = 0, exp1 = 0;
    bit pend1 = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend1 <= 1'b0;
            cyc1  <= 0;
            acc1  <= 0;
        end else begin
            if (pend1 && cyc1 >= acc1 + 1 && out_ready1) begin
                pend1 <= 1'b0;
            end else if (!pend1 && in_valid1) begin
                pend1 <= 1'b1;
                acc1  <= cyc1 + 1;
                exp1  <= model_sub(1, int'(a1), int'(b1), int'(bin1));
            end
            cyc1 <= cyc1 + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!pend8));
            chk("out_valid", 32'(out_valid), 32'(pend8 && cyc8 >= acc8 + W));
            if (pend8 && cyc8 >= acc8 + W) begin
                chk("d", 32'(d), 32'(exp8 & 8'hFF));
                chk("bout", 32'(bout), 32'(exp8[8]));
            end
            chk("w1_in_ready", 32'(in_ready1), 32'(!pend1));
            chk("w1_out_valid", 32'(out_valid1), 32'(pend1 && cyc1 >= acc1 + 1));
            if (pend1 && cyc1 >= acc1 + 1) begin
                chk("w1_d", 32'(d1), 32'(exp1[0]));
                chk("w1_bout", 32'(bout1), 32'(exp1[1]));
            end
        end
    end

    // One WIDTH=8 transaction; called and returns just after a rising edge.
    task automatic txn(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                       input int hold, input logic junk,
                       output logic [7:0] rd, output logic rbo, output int lat);
        int n;
        a = ta; b = tbv; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #2; n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        in_valid = junk;
        if (junk) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rd = d; rbo = bout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        $display("txn a=%02h b=%02h bin=%0d -> d=%02h bout=%0d lat=%0d hold=%0d",
                 ta, tbv, tbin, rd, rbo, lat, hold);
    endtask

    logic [7:0] rd;
    logic       rbo;
    int         lat;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_d", 32'(d), 32'(0));
        chk("rst_bout", 32'(bout), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the reference model with hand-computed values
        chk("model_35_12", 32'(model_sub(8, 'h35, 'h12, 0)), 32'h023);
        chk("model_00_01", 32'(model_sub(8, 'h00, 'h01, 0)), 32'h1FF);
        chk("model_80_7F_1", 32'(model_sub(8, 'h80, 'h7F, 1)), 32'h000);
        chk("model_00_00_1", 32'(model_sub(8, 'h00, 'h00, 1)), 32'h1FF);
        chk("model_w1_0_1", 32'(model_sub(1, 0, 1, 0)), 32'h3);

        // Directed vectors
        txn(8'h35, 8'h12, 1'b0, 0, 1'b0, rd, rbo, lat);
        chk("dir_35_12_d", 32'(rd), 32'h23);
        chk("dir_35_12_bout", 32'(rbo), 32'(0));
        chk("dir_latency", 32'(lat), 32'(8));
        txn(8'h00, 8'h01, 1'b0, 0, 1'b0, rd, rbo, lat);
        chk("dir_00_01_d", 32'(rd), 32'hFF);
        chk("dir_00_01_bout", 32'(rbo), 32'(1));
        txn(8'h80, 8'h7F, 1'b1, 0, 1'b0, rd, rbo, lat);
        chk("dir_80_7F_d", 32'(rd), 32'h00);
        chk("dir_80_7F_bout", 32'(rbo), 32'(0));
        txn(8'h00, 8'h00, 1'b1, 0, 1'b0, rd, rbo, lat);
        chk("dir_00_00_d", 32'(rd), 32'hFF);
        chk("dir_00_00_bout", 32'(rbo), 32'(1));

        // Backpressure with ignored new operands while the result waits
        txn(8'h5A, 8'h3C, 1'b0, 5, 1'b1, rd, rbo, lat);
        chk("bp_d", 32'(rd), 32'h1E);
        chk("bp_bout", 32'(rbo), 32'(0));

        // Reset in the middle of RUN
        chk("pre_abort_ready", 32'(in_ready), 32'(1));
        a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_d", 32'(d), 32'(0));
        chk("abort_bout", 32'(bout), 32'(0));
        $display("txn a=aa b=55 aborted by reset");
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(8'h10, 8'h01, 1'b0, 0, 1'b0, rd, rbo, lat);
        chk("post_abort_d", 32'(rd), 32'h0F);
        chk("post_abort_bout", 32'(rbo), 32'(0));

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            txn(ra, rb, rbi, int'($urandom_range(0, 3)), 1'($urandom), rd, rbo, lat);
            chk("rand_result", 32'({rbo, rd}),
                32'(model_sub(8, int'(ra), int'(rb), int'(rbi))));
            chk("rand_latency", 32'(lat), 32'(8));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // WIDTH=1: back-to-back transactions with constant valid/ready
        begin
            int last_ready, n_acc;
            last_ready = -1; n_acc = 0;
            a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; out_ready1 = 1'b1; in_valid1 = 1'b1;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (in_ready1) begin
                    if (last_ready >= 0) chk("w1_interval", 32'(i - last_ready), 32'(3));
                    last_ready = i;
                    n_acc++;
                end
                if (out_valid1) begin
                    chk("w1_latency", 32'(i - last_ready), 32'(2));
                    chk("w1_result", 32'({bout1, d1}), 32'h3);
                    $display("w1 txn a=0 b=1 bin=0 -> d=%0d bout=%0d", d1, bout1);
                end
            end
            chk("w1_accepts", 32'(n_acc), 32'(6));
            #2;
            in_valid1 = 1'b0;
        end

        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
